// File: rtl/sequencer_pkg.sv
// Shared sequencer constants and the output FSM state type for the UART event arbiter.
package sequencer_pkg;
  localparam int NUM_BEATS = 16;
  // Width of the beat step field carried in a beat report byte.
  localparam int BEATS_BUFFER = 4;
  localparam logic [3:0] BEAT_MARKER = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    PRESENT,
    HOLDOFF
  } tx_state_t;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head output and occupancy count.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_wr   = wr_en & ~full;
  assign do_rd   = rd_en & ~empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/uart_event_arbiter.sv
// Merges matrix edit events (and, with UART_BEAT_REPORT_EN defined, beat reports)
// into a FIFO and offers them byte-by-byte to a UART transmitter.
module uart_event_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int NUM_BEATS  = sequencer_pkg::NUM_BEATS
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          edit_valid,
  input  logic [7:0]                    edit_data,
  input  logic                          beat_tick,
  input  logic [$clog2(NUM_BEATS)-1:0]  beat_count,
  output logic [7:0]                    tx_data,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [7:0]                    drop_count
);
  import sequencer_pkg::*;

  tx_state_t  state;
  tx_state_t  state_next;
  logic       edit_prev;
  logic       edit_edge;
  logic       edit_pend;
  logic [7:0] edit_byte;
  logic       edit_wr;
  logic       fifo_wr;
  logic       fifo_rd;
  logic [7:0] fifo_wdata;
  logic [7:0] fifo_rdata;
  logic       fifo_full;
  logic       fifo_empty;

  assign edit_edge = edit_valid & ~edit_prev;
  assign edit_wr   = fifo_wr & edit_pend;

`ifdef UART_BEAT_REPORT_EN
  logic                    beat_pend;
  logic [BEATS_BUFFER-1:0] beat_nib;

  assign fifo_wr    = ~fifo_full & (edit_pend | beat_pend);
  assign fifo_wdata = edit_pend ? edit_byte : {BEAT_MARKER, beat_nib};

  // A newer tick simply coalesces into the pending beat slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_pend <= 1'b0;
      beat_nib  <= '0;
    end else if (beat_tick) begin
      beat_pend <= 1'b1;
      beat_nib  <= BEATS_BUFFER'(beat_count);
    end else if (fifo_wr & ~edit_pend) begin
      beat_pend <= 1'b0;
    end
  end
`else
  logic unused_beat;
  assign unused_beat = ^{beat_tick, beat_count};
  assign fifo_wr     = ~fifo_full & edit_pend;
  assign fifo_wdata  = edit_byte;
`endif

  // Edge register resets high so a button held across reset release is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      edit_prev  <= 1'b1;
      edit_pend  <= 1'b0;
      edit_byte  <= '0;
      drop_count <= '0;
    end else begin
      edit_prev <= edit_valid;
      if (edit_edge) begin
        edit_pend <= 1'b1;
        edit_byte <= edit_data;
        if (edit_pend && !edit_wr && drop_count != 8'hFF)
          drop_count <= drop_count + 8'd1;
      end else if (edit_wr) begin
        edit_pend <= 1'b0;
      end
    end
  end

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (fifo_wr),
    .wr_data (fifo_wdata),
    .rd_en   (fifo_rd),
    .rd_data (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!fifo_empty) state_next = PRESENT;
      PRESENT: if (tx_ready) state_next = HOLDOFF;
      HOLDOFF: state_next = fifo_empty ? IDLE : PRESENT;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    tx_valid = (state == PRESENT);
    tx_data  = (state == PRESENT) ? fifo_rdata : '0;
  end

  assign fifo_rd = tx_valid & tx_ready;
endmodule

// File: tb/tb_uart_event_arbiter.sv
// Self-checking bench for uart_event_arbiter: vector table, directed sequences, random vs model.
module tb_uart_event_arbiter;
  localparam int DEPTH = 4;
`ifdef UART_BEAT_REPORT_EN
  localparam bit BEAT_EN = 1'b1;
`else
  localparam bit BEAT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       edit_valid;
  logic [7:0] edit_data;
  logic       beat_tick;
  logic [3:0] beat_count;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [2:0] fifo_count;
  logic [7:0] drop_count;

  int checks = 0;
  int failures = 0;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];

  // Behavioural model state
  logic [7:0] mq[$];
  bit         m_ep, m_bp, m_prev, m_pres, m_hold;
  logic [7:0] m_eb;
  logic [3:0] m_bn;
  int         m_drop;

  typedef struct {
    logic       ev;
    logic [7:0] d;
    logic       rdy;
    logic       xv;
    logic [7:0] xd;
    logic [2:0] xc;
    logic [7:0] xdrop;
  } vec_t;
  vec_t tbl[13];

  uart_event_arbiter #(.FIFO_DEPTH(DEPTH), .NUM_BEATS(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .edit_valid (edit_valid),
    .edit_data  (edit_data),
    .beat_tick  (beat_tick),
    .beat_count (beat_count),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .fifo_count (fifo_count),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (!rst && tx_valid && tx_ready) got.push_back(tx_data);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_bytes(input string name);
    logic [7:0] a;
    check({name, "_len"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      a = 'x;
      if (i < got.size()) a = got[i];
      check(name, a, exp_q[i]);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic model_step();
    int         sz0     = mq.size();
    bit         edge_ev = edit_valid && !m_prev;
    bit         wr      = (sz0 < DEPTH) && (m_ep || m_bp);
    bit         wr_edit = wr && m_ep;
    logic [7:0] wbyte   = m_ep ? m_eb : {4'hF, m_bn};
    if (m_pres && tx_ready) void'(mq.pop_front());
    if (wr) mq.push_back(wbyte);
    if (BEAT_EN && beat_tick) begin
      m_bp = 1;
      m_bn = beat_count;
    end else if (wr && !m_ep) begin
      m_bp = 0;
    end
    if (edge_ev) begin
      if (m_ep && !wr_edit && m_drop < 255) m_drop++;
      m_ep = 1;
      m_eb = edit_data;
    end else if (wr_edit) begin
      m_ep = 0;
    end
    if (m_pres) begin
      if (tx_ready) begin
        m_pres = 0;
        m_hold = 1;
      end
    end else begin
      m_hold = 0;
      m_pres = (sz0 > 0);
    end
    m_prev = edit_valid;
  endtask

  task automatic do_reset();
    rst = 1; edit_valid = 0; edit_data = 0; beat_tick = 0; beat_count = 0; tx_ready = 0;
    tick(2);
    rst = 0;
    mq.delete();
    m_ep = 0; m_bp = 0; m_prev = 1; m_pres = 0; m_hold = 0; m_eb = 0; m_bn = 0; m_drop = 0;
    model_step();
    tick(1);
    got.delete();
  endtask

  task automatic edit_pulse(input logic [7:0] d);
    edit_valid = 1; edit_data = d;
    tick(1);
    edit_valid = 0;
    tick(1);
  endtask

  initial begin
    int nf, ne, ok3a, pct;
    logic [7:0] xd_m;

    tbl[0]  = '{1'b1, 8'h3A, 1'b0, 1'b0, 8'h00, 3'd0, 8'd0};
    tbl[1]  = '{1'b1, 8'h3A, 1'b0, 1'b0, 8'h00, 3'd1, 8'd0};
    tbl[2]  = '{1'b1, 8'h3A, 1'b0, 1'b1, 8'h3A, 3'd1, 8'd0};
    tbl[3]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h3A, 3'd1, 8'd0};
    tbl[4]  = '{1'b1, 8'h55, 1'b0, 1'b1, 8'h3A, 3'd1, 8'd0};
    tbl[5]  = '{1'b1, 8'h55, 1'b1, 1'b0, 8'h00, 3'd1, 8'd0};
    tbl[6]  = '{1'b1, 8'h55, 1'b1, 1'b1, 8'h55, 3'd1, 8'd0};
    tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 3'd0, 8'd0};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 3'd0, 8'd0};
    tbl[9]  = '{1'b1, 8'hF3, 1'b1, 1'b0, 8'h00, 3'd0, 8'd0};
    tbl[10] = '{1'b1, 8'hF3, 1'b1, 1'b0, 8'h00, 3'd1, 8'd0};
    tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hF3, 3'd1, 8'd0};
    tbl[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 3'd0, 8'd0};

    do_reset();
    check("reset_valid", tx_valid, 0);
    check("reset_data", tx_data, 0);
    check("reset_count", fifo_count, 0);
    check("reset_drop", drop_count, 0);

    for (int i = 0; i < 13; i++) begin
      edit_valid = tbl[i].ev; edit_data = tbl[i].d; tx_ready = tbl[i].rdy;
      tick(1);
      check($sformatf("vec%0d_valid", i), tx_valid, tbl[i].xv);
      check($sformatf("vec%0d_count", i), fifo_count, tbl[i].xc);
      check($sformatf("vec%0d_drop", i), drop_count, tbl[i].xdrop);
      if (tbl[i].xv) check($sformatf("vec%0d_data", i), tx_data, tbl[i].xd);
    end

    // Held button produces exactly one event
    do_reset();
    tx_ready = 1; edit_valid = 1; edit_data = 8'h3A;
    tick(1000);
    edit_valid = 0;
    tick(10);
    exp_q = {8'h3A};
    check_bytes("hold1000");
    check("hold1000_drop", drop_count, 0);

    // Simultaneous edit edge and beat tick
    do_reset();
    tx_ready = 1; edit_valid = 1; edit_data = 8'h21; beat_tick = 1; beat_count = 4'd5;
    tick(1);
    beat_tick = 0; edit_valid = 0;
    tick(10);
    exp_q = {8'h21};
    if (BEAT_EN) exp_q.push_back(8'hF5);
    check_bytes("simul");

    // Overflow: six edits with the UART stalled
    do_reset();
    for (int i = 0; i < 6; i++) edit_pulse(8'h11 + 8'(i));
    tick(3);
    check("ovf_count", fifo_count, 4);
    check("ovf_drop", drop_count, 1);
    tx_ready = 1;
    tick(30);
    exp_q = {8'h11, 8'h12, 8'h13, 8'h14, 8'h16};
    check_bytes("ovf_order");
    check("ovf_drain", fifo_count, 0);

    // Beat ticks coalesce while the FIFO is full
    do_reset();
    for (int i = 0; i < 4; i++) edit_pulse(8'h41 + 8'(i));
    tick(2);
    for (int c = 0; c < 10; c++) begin
      beat_tick = 1; beat_count = 4'(c);
      tick(1);
      beat_tick = 0;
      tick(1);
    end
    check("coal_count", fifo_count, 4);
    check("coal_drop", drop_count, 0);
    tx_ready = 1;
    tick(30);
    exp_q = {8'h41, 8'h42, 8'h43, 8'h44};
    if (BEAT_EN) exp_q.push_back(8'hF9);
    check_bytes("coal");

    // Reset mid-transfer with button held across release
    do_reset();
    for (int i = 0; i < 3; i++) edit_pulse(8'h51 + 8'(i));
    tick(2);
    check("mid_valid_pre", tx_valid, 1);
    check("mid_count_pre", fifo_count, 3);
    edit_valid = 1; edit_data = 8'h77; rst = 1;
    tick(1);
    check("mid_valid_rst", tx_valid, 0);
    check("mid_count_rst", fifo_count, 0);
    rst = 0; tx_ready = 1;
    got.delete();
    tick(20);
    check("mid_no_bytes", got.size(), 0);
    check("mid_count_end", fifo_count, 0);
    edit_valid = 0;
    tick(2);

    // Beat tick toggling during a held edit
    do_reset();
    tx_ready = 1; edit_valid = 1; edit_data = 8'h3A;
    for (int i = 0; i < 200; i++) begin
      beat_tick = ~beat_tick; beat_count = 4'(i);
      tick(1);
    end
    beat_tick = 0; edit_valid = 0;
    tick(10);
    nf = 0; ne = 0; ok3a = 0;
    foreach (got[i]) begin
      if (got[i][7:4] == 4'hF) nf++;
      else begin
        ne++;
        if (got[i] == 8'h3A) ok3a++;
      end
    end
    check("toggle_edit_bytes", ne, 1);
    check("toggle_edit_3a", ok3a, 1);
    check("toggle_beat_bytes", (nf > 0), BEAT_EN);

    // Randomized run against the model
    do_reset();
    for (int blk = 0; blk < 6; blk++) begin
      case (blk)
        0: pct = 90;
        1: pct = 15;
        2: pct = 60;
        3: pct = 3;
        4: pct = 100;
        default: pct = 40;
      endcase
      for (int n = 0; n < 500; n++) begin
        if ($urandom_range(2) == 0) edit_valid = ~edit_valid;
        edit_data  = 8'($urandom);
        beat_tick  = ($urandom_range(5) == 0);
        beat_count = 4'($urandom);
        tx_ready   = ($urandom_range(99) < pct);
        model_step();
        tick(1);
        xd_m = (mq.size() > 0) ? mq[0] : 8'h00;
        check("rnd_valid", tx_valid, m_pres);
        check("rnd_count", fifo_count, mq.size());
        check("rnd_drop", drop_count, m_drop);
        if (m_pres) check("rnd_data", tx_data, xd_m);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_event_arbiter.md
UART_EVENT_ARBITER -- requirements
Module: uart_event_arbiter

Interface
REQ-001 SHALL have parameters, one per line:
- FIFO_DEPTH, 4, entries in event FIFO, power of two, 2..16.
- NUM_BEATS, 16, sequencer steps.
REQ-002 SHALL have ports, one per line:
- clk  in  1  single system clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- edit_valid  in  1  level, high while a matrix button is held.
- edit_data  in  8  {pitch[3:0], button_index[3:0]}, sampled with edit_valid.
- beat_tick  in  1  one-cycle pulse on each step advance.
- beat_count  in  $clog2(NUM_BEATS)  current step, valid with beat_tick.
- tx_data  out  8  byte offered to uart_tx.
- tx_valid  out  1  offer strobe to uart_tx.
- tx_ready  in  1  uart_tx idle.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- drop_count  out  8  edit events lost, saturating.

Function
REQ-003 SHALL detect an edit event only on a rising edge of edit_valid; holding edit_valid high SHALL produce exactly one event.
REQ-004 SHALL hold two pending slots: edit (byte = edit_data at the edge) and beat (byte = {4'hF, beat_count} zero-extended to 4 bits).
REQ-005 SHALL write at most one pending slot per clock into the FIFO, fixed priority edit over beat, only when the FIFO is not full.
REQ-006 Simultaneous edit edge and beat_tick: both slots set in the same cycle; edit written first, beat on the following cycle.
REQ-007 New edit edge while the edit slot is still pending: newer byte replaces it; drop_count += 1, saturating at 255.
REQ-008 New beat_tick while the beat slot is pending: beat_count replaced (coalesced), no drop counted.
REQ-009 FIFO full: pending slots SHALL be held, not discarded, except as in REQ-007/008.
REQ-010 Output FSM states:
- IDLE: tx_valid=0.
- PRESENT: tx_valid=1, tx_data=FIFO head.
- HOLDOFF: tx_valid=0 for exactly one cycle.
REQ-011 FSM transitions:
- IDLE->PRESENT when FIFO non-empty.
- PRESENT->HOLDOFF on tx_valid&&tx_ready; FIFO pops on that same edge.
- HOLDOFF->PRESENT if non-empty, else IDLE.
REQ-012 tx_data SHALL remain stable while in PRESENT.
REQ-013 Latency, empty system: clock edge k samples the edit rising edge -> slot set after k, FIFO written on k+1, tx_valid high after k+2.
REQ-014 Simultaneous FIFO write and pop SHALL keep fifo_count unchanged; full and empty SHALL never both be true.
REQ-015 Pitch code 4'hF is reserved as the beat marker; edits carrying pitch 15 SHALL be forwarded unchanged (host disambiguation out of scope).

Reset
REQ-016 On rst: FSM=IDLE, tx_valid=0, tx_data=0, fifo_count=0, drop_count=0, both slots clear, FIFO pointers 0.
REQ-017 On rst: edit edge register SHALL be set to 1, so a button held across reset release generates no event.
REQ-018 rst asserted mid-transfer SHALL abandon the in-flight byte and all queued and pending events.

Configuration
REQ-019 Macro UART_BEAT_REPORT_EN.
- Defined: beat slot and REQ-004/006/008 present.
- Undefined: beat_tick and beat_count ignored, beat slot logic absent, only edit bytes sent; all other behaviour identical.

Structure
REQ-020 Shared package sequencer_pkg SHALL hold:
- NUM_BEATS and BEATS_BUFFER.
- BEAT_MARKER (4'hF).
- the output FSM state enum {IDLE, PRESENT, HOLDOFF}.
REQ-021 FIFO SHALL be a separate sub-module sync_fifo (parameterised width/depth, single read/write port, full/empty/count outputs).

Verification
REQ-022 edit_valid high for 1000 cycles with edit_data=8'h3A, tx_ready=1 -> exactly one tx_valid pulse, tx_data=8'h3A, drop_count=0.
REQ-023 Same-cycle edit edge (8'h21) and beat_tick (beat_count=5), tx_ready=1 -> bytes 8'h21 then 8'hF5, in that order.
REQ-024 tx_ready=0, 6 distinct edit edges, FIFO_DEPTH=4 -> fifo_count=4, one pending edit, drop_count=1; release tx_ready -> 5 bytes out in arrival order, oldest overwritten byte absent.
REQ-025 Ten beat_ticks (counts 0..9) with tx_ready=0 and FIFO full -> after release, FIFO contents plus one beat byte 8'hF9 only.
REQ-026 rst pulsed while in PRESENT with 3 queued -> next cycle tx_valid=0, fifo_count=0; edit_valid held through reset release -> no byte sent.
REQ-027 Build without UART_BEAT_REPORT_EN, beat_tick toggling -> no 8'hFx bytes; edits as in REQ-022.
